// File: rtl/cpu86_exec_trace_buf.sv
// Execution trace buffer: captures retired-instruction register snapshots into a FIFO for a checker.
// Latency: one cycle from an accepted exec_valid to the record appearing on vld_* (registered head).
// Backpressure: vld_ready stalls the head; exec has no backpressure, so records arriving while full are dropped and counted.
module cpu86_exec_trace_buf #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exec_valid,
  input  logic [4:0]             exec_op,
  input  logic [3:0]             exec_code,
  input  logic [3:0]             exec_sreg,
  input  logic [3:0]             exec_dreg,
  input  logic [15:0]            exec_cs,
  input  logic [15:0]            exec_ip,
  input  logic [15:0]            exec_ax,
  input  logic [15:0]            exec_bx,
  input  logic [15:0]            exec_cx,
  input  logic [15:0]            exec_dx,
  input  logic [15:0]            exec_bp,
  input  logic [15:0]            exec_sp,
  input  logic [15:0]            exec_si,
  input  logic [15:0]            exec_di,
  input  logic [15:0]            exec_fl,
  output logic                   vld_valid,
  input  logic                   vld_ready,
  output logic [4:0]             vld_op,
  output logic [3:0]             vld_code,
  output logic [15:0]            vld_cs,
  output logic [15:0]            vld_ip,
  output logic [15:0]            vld_ax,
  output logic [15:0]            vld_bx,
  output logic [15:0]            vld_cx,
  output logic [15:0]            vld_dx,
  output logic [15:0]            vld_bp,
  output logic [15:0]            vld_sp,
  output logic [15:0]            vld_si,
  output logic [15:0]            vld_di,
  output logic [15:0]            vld_fl,
  output logic [3:0]             vld_sreg,
  output logic [3:0]             vld_dreg,
  output logic                   ovf,
  output logic [15:0]            drop_cnt,
  output logic                   illegal_seen,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = 193;
  localparam logic [4:0]    OP_ILLEGAL = 5'b10110;
  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [RW-1:0] r_mem [DEPTH];
  logic [RW-1:0] r_head;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_vld;
  logic          r_ovf;
  logic [15:0]   r_drop;
  logic          r_ill;

  logic [RW-1:0] w_rec;
  logic [RW-1:0] w_head_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [LW-1:0] w_level_nxt;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_bypass;

  assign w_rec  = {exec_op, exec_code, exec_sreg, exec_dreg, exec_cs, exec_ip, exec_ax,
                   exec_bx, exec_cx, exec_dx, exec_bp, exec_sp, exec_si, exec_di, exec_fl};
  assign w_pop  = r_vld & vld_ready;
  assign w_full = (r_level == LVL_FULL);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push = exec_valid & (~w_full | w_pop);
  assign w_drop = exec_valid & w_full & ~w_pop;
  // When nothing else will remain queued, the incoming record becomes the next head directly.
  assign w_bypass = (r_level == '0) | ((r_level == LVL_ONE) & w_pop);

  // Next read pointer, next occupancy and next head record.
  always_comb begin
    w_rptr_nxt  = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
    w_head_nxt = (w_push && w_bypass) ? w_rec : r_mem[w_rptr_nxt];
  end

  // Storage array; no reset needed since only written slots are ever read into the head.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  // Pointers, occupancy and the registered head presented to the checker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_vld   <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_vld   <= (w_level_nxt != '0);
      if (w_level_nxt != '0) begin
        r_head <= w_head_nxt;
      end
    end
  end

  // Sticky status: overflow flag, saturating drop counter, illegal-op capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
      r_ill  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) begin
          r_drop <= r_drop + 16'd1;
        end
      end
      if (w_push && (exec_op == OP_ILLEGAL)) begin
        r_ill <= 1'b1;
      end
    end
  end

  assign {vld_op, vld_code, vld_sreg, vld_dreg, vld_cs, vld_ip, vld_ax,
          vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl} = r_head;
  assign vld_valid    = r_vld;
  assign ovf          = r_ovf;
  assign drop_cnt     = r_drop;
  assign illegal_seen = r_ill;
  assign level        = r_level;

endmodule

// File: tb/tb_cpu86_exec_trace_buf.sv
// Directed bench for cpu86_exec_trace_buf with a queue scoreboard of accepted records.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_cpu86_exec_trace_buf;
  localparam int DEPTH = 8;
  localparam logic [4:0] OP_ILL = 5'b10110;

  logic clk = 1'b0;
  logic reset;
  logic exec_valid;
  logic [4:0] exec_op;
  logic [3:0] exec_code, exec_sreg, exec_dreg;
  logic [15:0] exec_cs, exec_ip, exec_ax, exec_bx, exec_cx, exec_dx, exec_bp, exec_sp, exec_si, exec_di, exec_fl;
  logic vld_valid, vld_ready;
  logic [4:0] vld_op;
  logic [3:0] vld_code, vld_sreg, vld_dreg;
  logic [15:0] vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl;
  logic ovf, illegal_seen;
  logic [15:0] drop_cnt;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int failures = 0;

  logic [192:0] mq[$];
  logic         movf;
  logic [15:0]  mdrop;
  logic         mill;

  always #5 clk = ~clk;

  cpu86_exec_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .exec_valid(exec_valid),
    .exec_op(exec_op), .exec_code(exec_code), .exec_sreg(exec_sreg), .exec_dreg(exec_dreg),
    .exec_cs(exec_cs), .exec_ip(exec_ip), .exec_ax(exec_ax), .exec_bx(exec_bx), .exec_cx(exec_cx),
    .exec_dx(exec_dx), .exec_bp(exec_bp), .exec_sp(exec_sp), .exec_si(exec_si), .exec_di(exec_di),
    .exec_fl(exec_fl),
    .vld_valid(vld_valid), .vld_ready(vld_ready),
    .vld_op(vld_op), .vld_code(vld_code), .vld_cs(vld_cs), .vld_ip(vld_ip), .vld_ax(vld_ax),
    .vld_bx(vld_bx), .vld_cx(vld_cx), .vld_dx(vld_dx), .vld_bp(vld_bp), .vld_sp(vld_sp),
    .vld_si(vld_si), .vld_di(vld_di), .vld_fl(vld_fl), .vld_sreg(vld_sreg), .vld_dreg(vld_dreg),
    .ovf(ovf), .drop_cnt(drop_cnt), .illegal_seen(illegal_seen), .level(level)
  );

  function automatic logic [192:0] in_rec();
    return {exec_op, exec_code, exec_sreg, exec_dreg, exec_fl, exec_di, exec_si, exec_sp,
            exec_bp, exec_dx, exec_cx, exec_bx, exec_ax, exec_ip, exec_cs};
  endfunction

  function automatic logic [192:0] out_rec();
    return {vld_op, vld_code, vld_sreg, vld_dreg, vld_fl, vld_di, vld_si, vld_sp,
            vld_bp, vld_dx, vld_cx, vld_bx, vld_ax, vld_ip, vld_cs};
  endfunction

  task automatic check(input string tag, input logic [192:0] obs, input logic [192:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load random fields into the exec bus; op chosen by caller.
  task automatic set_rec(input logic [4:0] op);
    exec_op   = op;
    exec_code = 4'($urandom);
    exec_sreg = 4'($urandom);
    exec_dreg = 4'($urandom);
    exec_cs = 16'($urandom); exec_ip = 16'($urandom); exec_ax = 16'($urandom);
    exec_bx = 16'($urandom); exec_cx = 16'($urandom); exec_dx = 16'($urandom);
    exec_bp = 16'($urandom); exec_sp = 16'($urandom); exec_si = 16'($urandom);
    exec_di = 16'($urandom); exec_fl = 16'($urandom);
  endtask

  function automatic logic [4:0] legal_op();
    return 5'($urandom_range(0, 21));
  endfunction

  // One clock: score the pop/push of this cycle, advance, then check status against the model.
  task automatic tick();
    logic pop, push, stall;
    logic [192:0] held;
    pop   = (mq.size() != 0) && vld_ready;
    push  = exec_valid && ((mq.size() < DEPTH) || pop);
    stall = (mq.size() != 0) && !vld_ready;
    held  = out_rec();
    if (pop) begin
      check("pop_data", out_rec(), mq[0]);
      void'(mq.pop_front());
    end
    if (exec_valid && !push) begin
      movf = 1'b1;
      if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
    end
    if (push) begin
      mq.push_back(in_rec());
      if (exec_op == OP_ILL) mill = 1'b1;
    end
    @(posedge clk); #1;
    check("level", 193'(level), 193'(mq.size()));
    check("vld_valid", 193'(vld_valid), 193'(mq.size() != 0));
    check("ovf", 193'(ovf), 193'(movf));
    check("drop_cnt", 193'(drop_cnt), 193'(mdrop));
    check("illegal_seen", 193'(illegal_seen), 193'(mill));
    if (stall) check("stall_hold", out_rec(), held);
  endtask

  task automatic model_clear();
    mq.delete();
    movf = 1'b0;
    mdrop = '0;
    mill = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exec_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1; vld_ready = 1'b0;
    set_rec(5'd1);
    exec_valid = 1'b1;  // must be ignored during reset
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 193'(level), 193'(0));
    check("rst_vld_valid", 193'(vld_valid), 193'(0));
    check("rst_ovf", 193'(ovf), 193'(0));
    check("rst_drop_cnt", 193'(drop_cnt), 193'(0));
    check("rst_illegal", 193'(illegal_seen), 193'(0));
    check("rst_vld_data", out_rec(), 193'(0));
    exec_valid = 1'b0;
    reset = 1'b0;

    // Single record with one-cycle latency.
    vld_ready = 1'b1;
    set_rec(legal_op()); exec_ip = 16'h0100; exec_ax = 16'h1234; exec_valid = 1'b1;
    tick();
    check("single_valid", 193'(vld_valid), 193'(1));
    check("single_ip", 193'(vld_ip), 193'(16'h0100));
    check("single_ax", 193'(vld_ax), 193'(16'h1234));
    exec_valid = 1'b0;
    tick();
    check("single_after_valid", 193'(vld_valid), 193'(0));
    check("single_after_level", 193'(level), 193'(0));

    // Fill past capacity, then drain.
    vld_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_rec(legal_op()); exec_valid = 1'b1;
      tick();
    end
    exec_valid = 1'b0;
    check("fill_level", 193'(level), 193'(8));
    check("fill_ovf", 193'(ovf), 193'(1));
    check("fill_drop", 193'(drop_cnt), 193'(2));
    vld_ready = 1'b1;
    repeat (8) tick();
    check("drain_level", 193'(level), 193'(0));

    // Full with simultaneous push and pop.
    do_reset();
    vld_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_rec(legal_op()); exec_valid = 1'b1;
      tick();
    end
    set_rec(legal_op()); exec_ip = 16'hBEEF; vld_ready = 1'b1;
    tick();
    exec_valid = 1'b0;
    check("pp_full_level", 193'(level), 193'(8));
    check("pp_full_ovf", 193'(ovf), 193'(0));
    repeat (7) tick();
    check("pp_new_at_head", 193'(vld_ip), 193'(16'hBEEF));
    tick();

    // Stall hold with ready pattern 1,0,0,1 then drain.
    vld_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_rec(legal_op()); exec_valid = 1'b1;
      tick();
    end
    exec_valid = 1'b0;
    vld_ready = 1'b1; tick();
    vld_ready = 1'b0; tick();
    tick();
    vld_ready = 1'b1; tick();
    tick(); tick();
    check("stall_drained", 193'(level), 193'(0));

    // Illegal op captured and sticky.
    do_reset();
    vld_ready = 1'b1;
    set_rec(OP_ILL); exec_valid = 1'b1;
    tick();
    check("ill_set", 193'(illegal_seen), 193'(1));
    for (int i = 0; i < 100; i++) begin
      set_rec(legal_op());
      tick();
    end
    exec_valid = 1'b0;
    tick();
    check("ill_sticky", 193'(illegal_seen), 193'(1));

    // Illegal op dropped while full does not set the flag.
    do_reset();
    vld_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_rec(legal_op()); exec_valid = 1'b1;
      tick();
    end
    set_rec(OP_ILL);
    tick();
    exec_valid = 1'b0;
    tick();
    check("ill_dropped", 193'(illegal_seen), 193'(0));
    check("ill_drop_cnt", 193'(drop_cnt), 193'(1));

    // Mid-operation reset pulse of half a cycle.
    do_reset();
    vld_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_rec(legal_op()); exec_valid = 1'b1;
      tick();
    end
    exec_valid = 1'b0;
    check("pre_rst_level", 193'(level), 193'(5));
    reset = 1'b1;
    #2;
    check("mid_rst_level", 193'(level), 193'(0));
    check("mid_rst_valid", 193'(vld_valid), 193'(0));
    check("mid_rst_ovf", 193'(ovf), 193'(0));
    #3;
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    set_rec(legal_op()); exec_ip = 16'hCAFE; exec_valid = 1'b1; vld_ready = 1'b1;
    tick();
    exec_valid = 1'b0;
    check("post_rst_first_ip", 193'(vld_ip), 193'(16'hCAFE));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu86_exec_trace_buf.md
CPU86_EXEC_TRACE_BUF -- requirements
Module: cpu86_exec_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning trace FIFO entry count; power of two, 2..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port exec_valid, input, 1, marks one retired instruction's register snapshot this cycle; there is no backpressure to exec.
REQ-005 SHALL have ports exec_op (5), exec_code (4), exec_sreg (4) and exec_dreg (4), all inputs, carrying opcode class, sub-code, source register and destination register.
REQ-006 SHALL have ports exec_cs, exec_ip, exec_ax, exec_bx, exec_cx, exec_dx, exec_bp, exec_sp, exec_si, exec_di and exec_fl, all inputs, 16 bits each, carrying the post-execution architectural state.
REQ-007 SHALL have port vld_valid, output, 1, meaning a trace record is presented to the checker.
REQ-008 SHALL have port vld_ready, input, 1, meaning the checker accepts the record; a transfer occurs when vld_valid and vld_ready are both 1.
REQ-009 SHALL have ports vld_op, vld_code, vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl, vld_sreg and vld_dreg, all outputs, with widths matching their exec_* counterparts; they carry the head record.
REQ-010 SHALL have port ovf, output, 1, a sticky flag meaning at least one record was dropped.
REQ-011 SHALL have port drop_cnt, output, 16, a saturating count of dropped records.
REQ-012 SHALL have port illegal_seen, output, 1, a sticky flag meaning an op of 5'b10110 (ILLEGAL) was captured.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1 bits, giving the current occupancy.

Function
REQ-014 Each record SHALL be 193 bits: op 5, code 4, sreg 4, dreg 4, and eleven 16-bit registers; the field order is internal and fields SHALL be output bit-exact.
REQ-015 A push SHALL occur on exec_valid=1 when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-016 A pop SHALL occur on vld_valid=1 and vld_ready=1.
REQ-017 Latency SHALL be one cycle: a record pushed at edge N is presented with vld_valid=1 after edge N, even if the FIFO was empty; there is no combinational exec-to-vld path.
REQ-018 vld_valid SHALL equal (level!=0) and SHALL be registered.
REQ-019 vld_* fields SHALL hold stable while vld_valid=1 and vld_ready=0.
REQ-020 Records SHALL leave in strict arrival order, with no reordering and no duplication.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 level SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push and pop.
REQ-023 If exec_valid=1, level=DEPTH and no pop occurs, the record SHALL be discarded, ovf SHALL be set to 1, drop_cnt SHALL increment (saturating at 16'hFFFF), and FIFO contents SHALL be unchanged.
REQ-024 Simultaneous push and pop at level=DEPTH SHALL accept the push, pop the head, keep level=DEPTH and leave ovf unchanged.
REQ-025 Simultaneous push and pop at level=0 is impossible because vld_valid=0; the push SHALL proceed normally.
REQ-026 illegal_seen SHALL be set on any accepted push with exec_op=5'b10110 and SHALL remain set until reset; a dropped record SHALL NOT set it.
REQ-027 vld_* data while vld_valid=0 is don't-care but SHALL be X-free after reset.

Reset
REQ-028 While reset=1, the block SHALL asynchronously clear: pointers to 0, level to 0, vld_valid to 0, ovf to 0, drop_cnt to 0, illegal_seen to 0, and all vld_* data outputs to 0.
REQ-029 A reset asserted mid-operation SHALL discard all queued records; the first record after reset release SHALL be the first exec_valid sampled after release.
REQ-030 exec_valid SHALL be ignored while reset=1.

Verification
REQ-031 Scenario, single record: reset, then one exec_valid with ip=16'h0100, ax=16'h1234, vld_ready=1 -> vld_valid=1 exactly one cycle later with vld_ip=16'h0100 and vld_ax=16'h1234, then vld_valid=0 and level=0.
REQ-032 Scenario, fill and overflow: vld_ready=0 with 10 consecutive pushes, DEPTH=8 -> level=8, ovf=1, drop_cnt=2; draining outputs exactly pushes 1..8 in order.
REQ-033 Scenario, full with simultaneous push and pop: at level=8, apply exec_valid=1 and vld_ready=1 together -> level stays 8, ovf=0, and the new record appears 8 pops later.
REQ-034 Scenario, stall hold: vld_ready toggling 1,0,0,1 with 4 records queued -> vld_* stable during the stall cycles and all 4 records delivered in order.
REQ-035 Scenario, illegal op: push exec_op=5'b10110 -> illegal_seen=1 on the next cycle and remains 1 after 100 further records; the same op pushed while full and dropped leaves illegal_seen=0.
REQ-036 Scenario, mid-operation reset: with 5 records queued, pulse reset for half a cycle -> level=0, vld_valid=0 and ovf=0 immediately; the next push's record is the first one output.
